// File: rtl/pixel_sequencer.sv
// Frame sequencer for the pixel array: ERASE/EXPOSE/CONVERT phases with a ramp-ADC code counter,
// then row-by-row readout over valid/ready. Define PIXEL_SEQ_CONTINUOUS_EN for free-running frames.
module pixel_sequencer #(
   parameter int unsigned ADC_BITS     = 8,
   parameter int unsigned ROWS         = 4,
   parameter int unsigned ERASE_CYCLES = 5,
   parameter int unsigned EXP_W        = 16,
   localparam int unsigned ROW_W       = (ROWS > 1) ? $clog2(ROWS) : 1
) (
   input  logic                clk,
   input  logic                rst_n,
   input  logic                start,
   input  logic                abort,
   input  logic [EXP_W-1:0]    expose_time,
   input  logic [ADC_BITS-1:0] data_in,
   output logic                erase,
   output logic                expose,
   output logic                convert,
   output logic [ADC_BITS-1:0] adc_code,
   output logic [ROWS-1:0]     read,
   output logic [ADC_BITS-1:0] out_data,
   output logic [ROW_W-1:0]    out_row,
   output logic                out_valid,
   input  logic                out_ready,
   output logic                busy,
   output logic                frame_done
);

   typedef enum logic [2:0] {
      StIdle,
      StErase,
      StExpose,
      StConvert,
      StRsel,
      StRcap,
      StRwait,
      StDone
   } state_e;

   localparam int unsigned         ERASE_W    = $clog2(ERASE_CYCLES + 1);
   localparam logic [ERASE_W-1:0]  ERASE_LOAD = ERASE_W'(ERASE_CYCLES - 1);
   localparam logic [ADC_BITS-1:0] CODE_MAX   = '1;
   localparam logic [ROW_W-1:0]    ROW_LAST   = ROW_W'(ROWS - 1);

   state_e             state_q;
   logic [ERASE_W-1:0] erase_cnt_q;
   logic [EXP_W-1:0]   exp_len_q;
   logic [EXP_W-1:0]   exp_cnt_q;
   logic [ROW_W-1:0]   row_q;
   logic [EXP_W-1:0]   exp_len_d;

   // Zero exposure is promoted to one cycle so EXPOSE is never skipped.
   assign exp_len_d = (expose_time == '0) ? EXP_W'(1) : expose_time;

   function automatic logic [ROWS-1:0] row_sel(input logic [ROW_W-1:0] r);
      return ROWS'(1) << r;
   endfunction

   always_ff @(posedge clk or negedge rst_n) begin
      if (!rst_n) begin
         state_q     <= StIdle;
         erase_cnt_q <= '0;
         exp_len_q   <= '0;
         exp_cnt_q   <= '0;
         row_q       <= '0;
         erase       <= 1'b0;
         expose      <= 1'b0;
         convert     <= 1'b0;
         adc_code    <= '0;
         read        <= '0;
         out_data    <= '0;
         out_row     <= '0;
         out_valid   <= 1'b0;
         busy        <= 1'b0;
         frame_done  <= 1'b0;
      end else if (abort) begin
         // Abort drops everything, including a pending OUT_VALID, and beats START.
         state_q     <= StIdle;
         erase_cnt_q <= '0;
         exp_len_q   <= '0;
         exp_cnt_q   <= '0;
         row_q       <= '0;
         erase       <= 1'b0;
         expose      <= 1'b0;
         convert     <= 1'b0;
         adc_code    <= '0;
         read        <= '0;
         out_data    <= '0;
         out_row     <= '0;
         out_valid   <= 1'b0;
         busy        <= 1'b0;
         frame_done  <= 1'b0;
      end else begin
         frame_done <= 1'b0;
         unique case (state_q)
            StIdle: begin
               if (start) begin
                  state_q     <= StErase;
                  erase       <= 1'b1;
                  busy        <= 1'b1;
                  erase_cnt_q <= ERASE_LOAD;
                  exp_len_q   <= exp_len_d;
               end
            end
            StErase: begin
               if (erase_cnt_q == '0) begin
                  state_q   <= StExpose;
                  erase     <= 1'b0;
                  expose    <= 1'b1;
                  exp_cnt_q <= exp_len_q - 1'b1;
               end else begin
                  erase_cnt_q <= erase_cnt_q - 1'b1;
               end
            end
            StExpose: begin
               if (exp_cnt_q == '0) begin
                  state_q  <= StConvert;
                  expose   <= 1'b0;
                  convert  <= 1'b1;
                  adc_code <= '0;
               end else begin
                  exp_cnt_q <= exp_cnt_q - 1'b1;
               end
            end
            StConvert: begin
               if (adc_code == CODE_MAX) begin
                  state_q  <= StRsel;
                  convert  <= 1'b0;
                  adc_code <= '0;
                  row_q    <= '0;
                  read     <= row_sel('0);
               end else begin
                  adc_code <= adc_code + 1'b1;
               end
            end
            StRsel: begin
               state_q <= StRcap;
            end
            StRcap: begin
               state_q   <= StRwait;
               out_data  <= data_in;
               out_row   <= row_q;
               out_valid <= 1'b1;
            end
            StRwait: begin
               if (out_valid && out_ready) begin
                  out_valid <= 1'b0;
                  if (row_q == ROW_LAST) begin
                     state_q    <= StDone;
                     read       <= '0;
                     frame_done <= 1'b1;
                  end else begin
                     state_q <= StRsel;
                     row_q   <= row_q + 1'b1;
                     read    <= row_sel(row_q + 1'b1);
                  end
               end
            end
            StDone: begin
`ifdef PIXEL_SEQ_CONTINUOUS_EN
               // Free-running: restart with the exposure latched at the last START.
               state_q     <= StErase;
               erase       <= 1'b1;
               erase_cnt_q <= ERASE_LOAD;
`else
               state_q <= StIdle;
               busy    <= 1'b0;
`endif
            end
            default: begin
               state_q <= StIdle;
            end
         endcase
      end
   end

endmodule

// File: tb/tb_pixel_sequencer.sv
// Self-checking bench for pixel_sequencer: directed and randomized frames checked against
// phase-timing arithmetic and a stream scoreboard of expected row codes.
module tb_pixel_sequencer;

   localparam int ADC_BITS     = 4;
   localparam int ROWS         = 4;
   localparam int ERASE_CYCLES = 3;
   localparam int EXP_W        = 8;
   localparam int ROW_W        = 2;
   localparam int NCODES       = 1 << ADC_BITS;

   logic                clk = 1'b0;
   logic                rst_n = 1'b0;
   logic                start = 1'b0;
   logic                abort = 1'b0;
   logic                out_ready = 1'b0;
   logic [EXP_W-1:0]    expose_time = '0;
   logic [ADC_BITS-1:0] data_in;
   logic                erase, expose, convert, busy, frame_done, out_valid;
   logic [ADC_BITS-1:0] adc_code, out_data;
   logic [ROWS-1:0]     read;
   logic [ROW_W-1:0]    out_row;
   logic [19:0]         outs;

   int tests = 0;
   int fails = 0;
   logic [ADC_BITS-1:0] pix [ROWS];

   pixel_sequencer #(
      .ADC_BITS    (ADC_BITS),
      .ROWS        (ROWS),
      .ERASE_CYCLES(ERASE_CYCLES),
      .EXP_W       (EXP_W)
   ) dut (
      .clk        (clk),
      .rst_n      (rst_n),
      .start      (start),
      .abort      (abort),
      .expose_time(expose_time),
      .data_in    (data_in),
      .erase      (erase),
      .expose     (expose),
      .convert    (convert),
      .adc_code   (adc_code),
      .read       (read),
      .out_data   (out_data),
      .out_row    (out_row),
      .out_valid  (out_valid),
      .out_ready  (out_ready),
      .busy       (busy),
      .frame_done (frame_done)
   );

   always #5 clk = ~clk;

   // Pixel array model: the selected row drives its stored code.
   always_comb begin
      data_in = '0;
      for (int r = 0; r < ROWS; r++) begin
         if (read[r]) data_in = pix[r];
      end
   end

   assign outs = {erase, expose, convert, adc_code, read, out_data, out_row, out_valid, busy,
                  frame_done};

   task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
      tests++;
      assert (obs === exp)
      else begin
         fails++;
         $error("FAIL %s: observed %0d expected %0d", tag, obs, exp);
      end
   endtask

   task automatic load_pix(input bit rnd);
      for (int r = 0; r < ROWS; r++) begin
         pix[r] = rnd ? ADC_BITS'($urandom_range(0, NCODES - 1)) : ADC_BITS'(r * 3 + 1);
      end
   endtask

   // One frame. mode 0: ready high; 1: random ready; 2: ready low stall_len cycles on stall_row.
   // do_start=0 continues a free-running frame whose first ERASE cycle is the current one.
   task automatic run_frame(input string tag, input bit do_start, input int t_req, input int mode,
                            input int stall_row, input int stall_len, input int start_at);
      int t, n_er, f_er, n_ex, f_ex, n_cv, f_cv, adc_err, hot_err, busy_err, stab_err, lat_err;
      int n_fd, c_fd, stalls, row_stall, c_read, data_err, exp_done;
      logic [ROWS-1:0] prev_read;
      logic prev_valid, hold;
      logic [ROWS+ADC_BITS+ROW_W:0] held;
      int got_row[$];
      int got_dat[$];
      t = (t_req == 0) ? 1 : t_req;
      n_er = 0; f_er = 0; n_ex = 0; f_ex = 0; n_cv = 0; f_cv = 0; adc_err = 0; hot_err = 0;
      busy_err = 0; stab_err = 0; lat_err = 0; n_fd = 0; c_fd = 0; stalls = 0; row_stall = 0;
      c_read = 0; data_err = 0; prev_read = '0; prev_valid = 1'b0; hold = 1'b0; held = '0;
      if (do_start) begin
         expose_time = EXP_W'(t_req);
         out_ready = 1'b1;
         start = 1'b1;
         @(posedge clk);
         #1 start = 1'b0;
      end else begin
         expose_time = EXP_W'($urandom_range(0, 255));
      end
      for (int c = 1; c <= 3000; c++) begin
         if (erase) begin n_er++; if (f_er == 0) f_er = c; end
         if (expose) begin n_ex++; if (f_ex == 0) f_ex = c; end
         if (convert) begin
            n_cv++;
            if (f_cv == 0) f_cv = c;
            if (adc_code !== ADC_BITS'(c - f_cv)) adc_err++;
         end else if (adc_code !== '0) adc_err++;
         if (int'(erase) + int'(expose) + int'(convert) > 1) hot_err++;
         if (c_fd == 0 && busy !== 1'b1) busy_err++;
         if (read != '0 && read != prev_read) c_read = c;
         if (out_valid && !prev_valid && (c - c_read) != 2) lat_err++;
         if (hold && {read, out_data, out_row, out_valid} !== held) stab_err++;
         if (c_fd != 0 && c == c_fd + 1) begin
            check({tag, "/done_width"}, frame_done, 0);
`ifdef PIXEL_SEQ_CONTINUOUS_EN
            check({tag, "/erase_after_done"}, erase, 1);
            check({tag, "/busy_after_done"}, busy, 1);
`else
            check({tag, "/busy_after_done"}, busy, 0);
`endif
            break;
         end
         if (frame_done) begin n_fd++; if (c_fd == 0) c_fd = c; end
         case (mode)
            1: out_ready = 1'($urandom_range(0, 1));
            2: out_ready = !(out_valid && int'(out_row) == stall_row && row_stall < stall_len);
            default: out_ready = 1'b1;
         endcase
         if (out_valid && !out_ready) begin
            stalls++;
            if (int'(out_row) == stall_row) row_stall++;
         end
         if (out_valid && out_ready) begin
            got_row.push_back(int'(out_row));
            got_dat.push_back(int'(out_data));
         end
         hold = out_valid && !out_ready;
         held = {read, out_data, out_row, out_valid};
         prev_read = read;
         prev_valid = out_valid;
         start = (c == start_at);
         @(posedge clk);
         #1;
      end
      start = 1'b0;
      exp_done = ERASE_CYCLES + t + NCODES + 3 * ROWS + 1 + stalls;
      check({tag, "/erase_len"}, n_er, ERASE_CYCLES);
      check({tag, "/erase_first"}, f_er, 1);
      check({tag, "/expose_len"}, n_ex, t);
      check({tag, "/expose_first"}, f_ex, ERASE_CYCLES + 1);
      check({tag, "/convert_len"}, n_cv, NCODES);
      check({tag, "/convert_first"}, f_cv, ERASE_CYCLES + t + 1);
      check({tag, "/adc_ramp"}, adc_err, 0);
      check({tag, "/phase_onehot"}, hot_err, 0);
      check({tag, "/busy"}, busy_err, 0);
      check({tag, "/valid_latency"}, lat_err, 0);
      check({tag, "/stall_stable"}, stab_err, 0);
      check({tag, "/rows_out"}, got_row.size(), ROWS);
      for (int i = 0; i < got_row.size(); i++) begin
         if (i >= ROWS || got_row[i] != i || got_dat[i] != int'(pix[i])) data_err++;
      end
      check({tag, "/row_data"}, data_err, 0);
      check({tag, "/done_count"}, n_fd, 1);
      check({tag, "/done_cycle"}, c_fd, exp_done);
      if (mode == 2) check({tag, "/stall_cycles"}, stalls, stall_len);
   endtask

   initial begin
      int found, n;
      // Reset state, checked while reset is asserted.
      #2 check("reset/outs_async", outs, 0);
      @(posedge clk);
      #1 check("reset/outs_held", outs, 0);
      @(negedge clk) rst_n = 1'b1;

      load_pix(1'b0);
`ifdef PIXEL_SEQ_CONTINUOUS_EN
      run_frame("cont0", 1'b1, 5, 0, 0, 0, 0);
      run_frame("cont1", 1'b0, 5, 0, 0, 0, 0);
      run_frame("cont2", 1'b0, 5, 0, 0, 0, 0);
      abort = 1'b1;
      @(posedge clk);
      #1 abort = 1'b0;
      check("cont/abort_outs", outs, 0);
      n = 0;
      for (int i = 0; i < 40; i++) begin
         @(posedge clk);
         #1 if (busy || erase || frame_done) n++;
      end
      check("cont/abort_idle", n, 0);
`else
      run_frame("basic", 1'b1, 5, 0, 0, 0, 0);
      run_frame("stall", 1'b1, 5, 2, 1, 10, 0);
      // Zero exposure plus a START pulse during CONVERT that must be ignored.
      run_frame("exp0", 1'b1, 0, 0, 0, 0, 10);
      n = 0;
      for (int i = 0; i < 30; i++) begin
         @(posedge clk);
         #1 if (busy || erase || frame_done) n++;
      end
      check("exp0/no_second_frame", n, 0);

      for (int k = 0; k < 3; k++) begin
         load_pix(1'b1);
         run_frame($sformatf("rand%0d", k), 1'b1, int'($urandom_range(0, 20)), 1, 0, 0, 0);
      end
      load_pix(1'b1);
      run_frame("exp_max", 1'b1, (1 << EXP_W) - 1, 0, 0, 0, 0);
`endif

      // Abort during CONVERT at code 7, with START also high to test priority.
      load_pix(1'b0);
      expose_time = 8'd5;
      out_ready = 1'b1;
      start = 1'b1;
      @(posedge clk);
      #1 start = 1'b0;
      found = 0;
      for (int i = 0; i < 100 && found == 0; i++) begin
         if (convert && adc_code == 4'd7) found = 1;
         else begin
            @(posedge clk);
            #1;
         end
      end
      check("abort/reached_code7", found, 1);
      abort = 1'b1;
      start = 1'b1;
      @(posedge clk);
      #1 abort = 1'b0;
      start = 1'b0;
      check("abort/outs", outs, 0);
      n = 0;
      for (int i = 0; i < 60; i++) begin
         @(posedge clk);
         #1 if (busy || frame_done || erase) n++;
      end
      check("abort/quiet", n, 0);

`ifndef PIXEL_SEQ_CONTINUOUS_EN
      // Reset while a row waits for ready, then a full normal frame.
      expose_time = 8'd2;
      out_ready = 1'b0;
      start = 1'b1;
      @(posedge clk);
      #1 start = 1'b0;
      for (int i = 0; i < 200 && !out_valid; i++) begin
         @(posedge clk);
         #1;
      end
      check("rst_rwait/reached", out_valid, 1);
      #2 rst_n = 1'b0;
      #1 check("rst_rwait/outs", outs, 0);
      @(negedge clk) rst_n = 1'b1;
      load_pix(1'b1);
      run_frame("after_rst", 1'b1, 7, 0, 0, 0, 0);
`endif

      $display("[TB] %0d tests run, %0d failed", tests, fails);
      $finish;
   end

endmodule
